cpu_bus_responder: RTL

Memory-side responder for the cpu_4bit multiplexed external bus. It decodes the CPU's io_out strobes, latches the 7-bit address, commits nibble writes to an internal 128x4 RAM and returns read data on the CPU's 4-bit data-in pins. Two top addresses are memory-mapped I/O: a 4-bit output port and a read-only input status nibble. It replaces the external latch and SRAM at chip level.

---
 rtl/cpu_bus_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the cpu_4bit multiplexed bus: address latch, 128x4 nibble RAM,
// registered read path, and a memory-mapped output port / input status nibble.
module cpu_bus_responder #(
  parameter int                ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] PORT_ADDR   = 7'h7F,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 7'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_out,
  input  logic [3:0] ext_in,
  output logic [3:0] rd_data,
  output logic [3:0] port_out,
  output logic       port_strobe,
  output logic [7:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, WR} state_t;

  logic [3:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wdata_q, wdata_d;
  logic [3:0]        rd_data_q, rd_data_d;
  logic [3:0]        port_out_q, port_out_d;
  logic              port_strobe_q, port_strobe_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              mem_we;

  logic addr_phase;
  logic n_we;
  logic unused_nds;

  assign addr_phase = bus_out[7];
  assign n_we       = bus_out[5];
  assign unused_nds = bus_out[4];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    port_out_d    = port_out_q;
    port_strobe_d = 1'b0;
    wr_count_d    = wr_count_q;
    mem_we        = 1'b0;

    if (addr_phase) begin
      addr_d = bus_out[ADDR_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (!addr_phase && !n_we) begin
          state_d = WR;
          wdata_d = bus_out[3:0];
        end
      end
      WR: begin
        if (n_we || addr_phase) begin
          // Commit goes to the address held before this edge, even if a new one is arriving.
          state_d = IDLE;
          if (addr_q == PORT_ADDR) begin
            port_out_d    = wdata_q;
            port_strobe_d = 1'b1;
            wr_count_d    = wr_count_q + 8'd1;
          end else if (addr_q != STATUS_ADDR) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + 8'd1;
          end
        end else begin
          wdata_d = bus_out[3:0];
        end
      end
      default: state_d = IDLE;
    endcase

    if (addr_q == STATUS_ADDR) begin
      rd_data_d = ext_in;
    end else if (addr_q == PORT_ADDR) begin
      rd_data_d = port_out_q;
    end else begin
      rd_data_d = mem[addr_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_data_q     <= '0;
      port_out_q    <= '0;
      port_strobe_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_data_q     <= rd_data_d;
      port_out_q    <= port_out_d;
      port_strobe_q <= port_strobe_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rd_data     = rd_data_q;
  assign port_out    = port_out_q;
  assign port_strobe = port_strobe_q;
  assign wr_count    = wr_count_q;

endmodule
